io_bank_arbiter: RTL and testbench

//  Time-shares the fabric's 10-pin bidirectional IO bank between NUM_REQ user-logic requesters.

---
 rtl/io_bank_arbiter.sv | 145 ++++++++++++++
 tb/tb_io_bank_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/io_bank_arbiter.sv
// Round-robin owner of a shared bidirectional IO bank, with a tristate turnaround
// gap between owners and a hold timeout that applies while others are waiting.
module io_bank_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int IO_W        = 10,
   parameter int TURN_CYCLES = 2,
   parameter int MAX_HOLD    = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req,
   output logic [NUM_REQ-1:0]      gnt,
   input  logic [NUM_REQ*IO_W-1:0] req_out,
   input  logic [NUM_REQ*IO_W-1:0] req_oeb,
   input  logic [IO_W-1:0]         io_in,
   output logic [IO_W-1:0]         io_out,
   output logic [IO_W-1:0]         io_oeb,
   output logic [IO_W-1:0]         io_rd,
   output logic                    busy,
   output logic                    timeout_pulse
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int HW = $clog2(MAX_HOLD);
   localparam int TW = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;

   state_t            state_reg, state_next;
   logic [PW-1:0]     rr_ptr_reg, rr_ptr_next;
   logic [PW-1:0]     owner_reg, owner_next;
   logic [NUM_REQ-1:0] gnt_reg, gnt_next;
   logic [HW-1:0]     hold_cnt_reg, hold_cnt_next;
   logic [TW-1:0]     turn_cnt_reg, turn_cnt_next;
   logic              timeout_pulse_reg, timeout_pulse_next;
   logic [IO_W-1:0]   io_rd_reg;

   logic [PW-1:0]      pick;
   logic [NUM_REQ-1:0] pick_onehot;
   logic [NUM_REQ-1:0] owner_onehot;
   logic               others_pending;
   logic [IO_W-1:0]    out_slice [NUM_REQ];
   logic [IO_W-1:0]    oeb_slice [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign pick_onehot[gi]  = (pick == PW'(gi));
         assign owner_onehot[gi] = (owner_reg == PW'(gi));
         assign out_slice[gi]    = req_out[gi*IO_W +: IO_W];
         assign oeb_slice[gi]    = req_oeb[gi*IO_W +: IO_W];
      end
   endgenerate

   assign others_pending = |(req & ~owner_onehot);

   // First requester at or after rr_ptr, wrapping.
   always_comb begin
      pick = rr_ptr_reg;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[(int'(rr_ptr_reg) + k) % NUM_REQ]) begin
            pick = PW'((int'(rr_ptr_reg) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      state_next         = state_reg;
      rr_ptr_next        = rr_ptr_reg;
      owner_next         = owner_reg;
      gnt_next           = gnt_reg;
      hold_cnt_next      = hold_cnt_reg;
      turn_cnt_next      = turn_cnt_reg;
      timeout_pulse_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (|req) begin
               owner_next = pick;
               if (TURN_CYCLES == 0) begin
                  state_next    = OWN;
                  gnt_next      = pick_onehot;
                  hold_cnt_next = '0;
               end else begin
                  state_next    = TURN;
                  turn_cnt_next = TW'(TURN_CYCLES);
               end
            end
         end
         TURN: begin
            if (!req[owner_reg]) begin
               state_next = IDLE;
            end else if (turn_cnt_reg == TW'(1)) begin
               // Counter reaches zero on this edge: the gap is exactly TURN_CYCLES long.
               state_next    = OWN;
               gnt_next      = owner_onehot;
               hold_cnt_next = '0;
               turn_cnt_next = '0;
            end else begin
               turn_cnt_next = turn_cnt_reg - TW'(1);
            end
         end
         OWN: begin
            if (!req[owner_reg] || (hold_cnt_reg == HOLD_MAX && others_pending)) begin
               state_next         = IDLE;
               gnt_next           = '0;
               rr_ptr_next        = (owner_reg == PW'(NUM_REQ - 1)) ? '0 : owner_reg + PW'(1);
               timeout_pulse_next = req[owner_reg];
            end else if (hold_cnt_reg != HOLD_MAX) begin
               hold_cnt_next = hold_cnt_reg + HW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= IDLE;
         rr_ptr_reg        <= '0;
         owner_reg         <= '0;
         gnt_reg           <= '0;
         hold_cnt_reg      <= '0;
         turn_cnt_reg      <= '0;
         timeout_pulse_reg <= 1'b0;
         io_rd_reg         <= '0;
      end else begin
         state_reg         <= state_next;
         rr_ptr_reg        <= rr_ptr_next;
         owner_reg         <= owner_next;
         gnt_reg           <= gnt_next;
         hold_cnt_reg      <= hold_cnt_next;
         turn_cnt_reg      <= turn_cnt_next;
         timeout_pulse_reg <= timeout_pulse_next;
         io_rd_reg         <= io_in;
      end
   end

   assign gnt           = gnt_reg;
   assign busy          = (state_reg != IDLE);
   assign timeout_pulse = timeout_pulse_reg;
   assign io_rd         = io_rd_reg;
   assign io_out        = (state_reg == OWN) ? out_slice[owner_reg] : '0;
   assign io_oeb        = (state_reg == OWN) ? oeb_slice[owner_reg] : '1;

endmodule

// File: tb/tb_io_bank_arbiter.sv
// Randomized bench for io_bank_arbiter; a timeline-based reference model
// (absolute grant/ownership cycle numbers) predicts every output each cycle.
module tb_io_bank_arbiter;
   localparam int N    = 2;
   localparam int W    = 10;
   localparam int TURN = 2;
   localparam int HOLD = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req;
   logic [N-1:0]     gnt;
   logic [N*W-1:0]   req_out;
   logic [N*W-1:0]   req_oeb;
   logic [W-1:0]     io_in;
   logic [W-1:0]     io_out;
   logic [W-1:0]     io_oeb;
   logic [W-1:0]     io_rd;
   logic             busy;
   logic             timeout_pulse;

   io_bank_arbiter #(.NUM_REQ(N), .IO_W(W), .TURN_CYCLES(TURN), .MAX_HOLD(HOLD)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt), .req_out(req_out), .req_oeb(req_oeb),
      .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .io_rd(io_rd), .busy(busy),
      .timeout_pulse(timeout_pulse)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: who owns the bus, who is waiting, and when things happen.
   int       m_own = -1;       // current owner, -1 = bus tristated
   int       m_wait = -1;      // requester waiting out the turnaround gap
   int       m_grant_at = 0;   // edge at which the waiting requester gets the bus
   int       m_own_since = 0;  // edge at which the current owner got the bus
   int       m_next = 0;       // requester that round-robin favours next
   bit       m_pulse = 1'b0;
   logic [W-1:0] m_rd = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_own = -1; m_wait = -1; m_next = 0; m_pulse = 1'b0; m_rd = '0;
      end else begin
         m_rd    = io_in;
         m_pulse = 1'b0;
         if (m_own >= 0) begin
            int cycles_owned = cyc - m_own_since;
            bool_others: begin end
            if (!req[m_own]) begin
               m_next = (m_own + 1) % N; m_own = -1;
            end else if (cycles_owned >= HOLD && (req & ~(N'(1) << m_own)) != 0) begin
               m_next = (m_own + 1) % N; m_own = -1; m_pulse = 1'b1;
            end
         end else if (m_wait >= 0) begin
            if (!req[m_wait]) m_wait = -1;
            else if (cyc == m_grant_at) begin
               m_own = m_wait; m_own_since = cyc; m_wait = -1;
               $display("grant to requester %0d at edge %0d", m_own, cyc);
            end
         end else if (req != 0) begin
            int p = -1;
            for (int k = 0; k < N; k++)
               if (p < 0 && req[(m_next + k) % N]) p = (m_next + k) % N;
            if (TURN == 0) begin
               m_own = p; m_own_since = cyc;
            end else begin
               m_wait = p; m_grant_at = cyc + TURN;
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic [N-1:0] q);
      logic [N-1:0] exp_gnt;
      logic [W-1:0] exp_out, exp_oeb;
      rst     = r;
      req     = q;
      req_out = (N*W)'({$urandom, $urandom});
      req_oeb = (N*W)'({$urandom, $urandom});
      io_in   = W'($urandom);
      @(posedge clk);
      model_edge();
      cyc++;
      @(negedge clk);
      exp_gnt = (m_own >= 0) ? (N'(1) << m_own) : '0;
      exp_out = (m_own >= 0) ? req_out[m_own*W +: W] : '0;
      exp_oeb = (m_own >= 0) ? req_oeb[m_own*W +: W] : '1;
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("io_out", 32'(io_out), 32'(exp_out));
      check("io_oeb", 32'(io_oeb), 32'(exp_oeb));
      check("io_rd", 32'(io_rd), 32'(m_rd));
      check("busy", 32'(busy), 32'(m_own >= 0 || m_wait >= 0));
      check("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
   endtask

   initial begin
      rst = 1'b1; req = '0; req_out = '0; req_oeb = '0; io_in = '0;
      // Reset for two cycles: bus tristated, nothing granted.
      step(1'b1, 2'b00);
      step(1'b1, 2'b00);
      // Single requester: grant lands three cycles after the request.
      for (int i = 0; i < 6; i++) step(1'b0, 2'b01);
      // Both request, requester 0 releases, requester 1 follows after the gap.
      step(1'b1, 2'b00);
      for (int i = 0; i < 5; i++) step(1'b0, 2'b11);
      for (int i = 0; i < 8; i++) step(1'b0, 2'b10);
      // Both held: owner revoked after MAX_HOLD cycles, repeatedly.
      step(1'b1, 2'b00);
      for (int i = 0; i < 30; i++) step(1'b0, 2'b11);
      // Request withdrawn during the turnaround, then re-requested.
      step(1'b1, 2'b00);
      step(1'b0, 2'b01);
      step(1'b0, 2'b01);
      step(1'b0, 2'b00);
      for (int i = 0; i < 6; i++) step(1'b0, 2'b01);
      // Lone owner holds past MAX_HOLD with nobody else waiting.
      for (int i = 0; i < 12; i++) step(1'b0, 2'b01);
      // Reset while owning.
      step(1'b1, 2'b01);
      step(1'b0, 2'b01);
      // Random traffic with sticky requests and rare resets.
      begin
         logic [N-1:0] q = '0;
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) q = N'($urandom);
            step(($urandom_range(0, 99) == 0), q);
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
